// File: rtl/simple_system_key_pkg.sv
`default_nettype none
// ============================================================================
// Module   : simple_system_key_pkg
// Brief    : Shared constants for the push-button debounce block.
// Revision : 1.0 - initial release
// ============================================================================
package simple_system_key_pkg;

    // 10 ms at 50 MHz
    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

    // Buttons are active-low
    localparam logic KEY_PRESSED  = 1'b0;
    localparam logic KEY_RELEASED = 1'b1;

endpackage : simple_system_key_pkg
`default_nettype wire

// File: rtl/simple_system_key_debounce_ch.sv
`default_nettype none
// ============================================================================
// Module   : simple_system_key_debounce_ch
// Brief    : One key channel: 2-flop synchroniser, stability counter,
//            clean level register and press/release strobes.
// Revision : 1.0 - initial release
// ============================================================================
module simple_system_key_debounce_ch
    import simple_system_key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_key_raw,
    output logic o_key_clean,
    output logic o_key_press,
    output logic o_key_release
);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_clean;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;
    logic             r_release;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1      <= KEY_RELEASED;
            r_s2      <= KEY_RELEASED;
            r_clean   <= KEY_RELEASED;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_s1      <= i_key_raw;
            r_s2      <= r_s1;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            // Any return to the clean level restarts the full stable interval
            if (r_s2 == r_clean) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_clean   <= r_s2;
                r_cnt     <= '0;
                r_press   <= (r_s2 == KEY_PRESSED);
                r_release <= (r_s2 == KEY_RELEASED);
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_key_clean   = r_clean;
    assign o_key_press   = r_press;
    assign o_key_release = r_release;

endmodule : simple_system_key_debounce_ch
`default_nettype wire

// File: rtl/simple_system_key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : simple_system_key_debounce
// Brief    : Debounces NUM_KEYS active-low push-buttons for the key PIO.
// Revision : 1.0 - initial release
// ============================================================================
module simple_system_key_debounce
    import simple_system_key_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_clean,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        simple_system_key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk           (clk),
            .reset_n       (reset_n),
            .i_key_raw     (key_raw[i]),
            .o_key_clean   (key_clean[i]),
            .o_key_press   (key_press[i]),
            .o_key_release (key_release[i])
        );
    end

endmodule : simple_system_key_debounce
`default_nettype wire
